// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS32 fetch front end.
// Holds the fetch FSM state encoding, the NOP bubble word, the PC width
// and the default reset fetch address.
package pipeline_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Frozen while en=0 (ID stalled). When enabled it
// either captures a delivered instruction or inserts a bubble (NOP, valid=0);
// flush forces the bubble even if an instruction is offered.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic            load,
  input  logic [31:0]     ir_in,
  input  logic [PC_W-1:0] pc_in,
  output logic [31:0]     IR,
  output logic [PC_W-1:0] pc_ID,
  output logic [PC_W-1:0] pc_plus4_ID,
  output logic            valid_ID
);

  // Capture a new instruction or a bubble whenever ID accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR          <= NOP_INSTR;
      pc_ID       <= '0;
      pc_plus4_ID <= PC_W'(4);
      valid_ID    <= 1'b0;
    end else if (en) begin
      if (load && !flush) begin
        IR          <= ir_in;
        pc_ID       <= pc_in;
        pc_plus4_ID <= pc_in + PC_W'(4);
        valid_ID    <= 1'b1;
      end else begin
        IR       <= NOP_INSTR;
        valid_ID <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: PC, imem request handshake, one-entry hold
// buffer and the IF/ID register.
// Handshake: imem_req stays high with imem_addr stable until a cycle in which
// imem_ack=1 (possibly the first request cycle); imem_rdata is valid only in
// that cycle. stall=1 freezes IF/ID; redirect is honoured only when stall=0.
// Optional macro IF_DELAY_SLOT_EN: branch delay slot (no flush on redirect,
// the next delivered instruction is kept and the PC then jumps).
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     IR,
  output logic [PC_W-1:0] pc_ID,
  output logic [PC_W-1:0] pc_plus4_ID,
  output logic            valid_ID,
  output fetch_state_t    state_dbg
);

  fetch_state_t    state;
  logic            req;
  logic [PC_W-1:0] pc;
  logic [31:0]     hold_ir;
  logic [PC_W-1:0] hold_pc;
  logic [PC_W-1:0] drop_target;

  logic            redir_ok;
  logic            ifid_load;
  logic            ifid_flush;
  logic [31:0]     ifid_ir;
  logic [PC_W-1:0] ifid_pc;
  logic [PC_W-1:0] next_seq_pc;
  logic [PC_W-1:0] redir_target;

`ifdef IF_DELAY_SLOT_EN
  logic            pending;
  logic [PC_W-1:0] pending_target;
  logic            redir_take;
  logic            deliver;
`endif

  assign imem_req  = req;
  assign imem_addr = pc;
  assign state_dbg = state;

  // Decide what IF/ID sees this cycle and where the PC goes after a delivery.
  always_comb begin
    redir_ok     = redirect & ~stall;
    redir_target = word_align(redirect_pc);
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_ir      = imem_rdata;
    ifid_pc      = pc;
    case (state)
      ST_REQ:  if (imem_ack && !stall) ifid_load = 1'b1;
      ST_HOLD: if (!stall) begin
                 ifid_load = 1'b1;
                 ifid_ir   = hold_ir;
                 ifid_pc   = hold_pc;
               end
      default: ;
    endcase
`ifdef IF_DELAY_SLOT_EN
    redir_take  = redir_ok & ~pending;
    deliver     = ifid_load;
    if (pending)         next_seq_pc = pending_target;
    else if (redir_take) next_seq_pc = redir_target;
    else                 next_seq_pc = pc + PC_W'(4);
`else
    ifid_flush  = redir_ok;
    next_seq_pc = pc + PC_W'(4);
`endif
  end

  // Fetch FSM: request handshake, PC update, hold buffer and drop tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      pc          <= word_align(RESET_PC);
      hold_ir     <= NOP_INSTR;
      hold_pc     <= '0;
      drop_target <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          req   <= 1'b1;
        end
        ST_REQ: begin
`ifndef IF_DELAY_SLOT_EN
          if (redir_ok) begin
            if (imem_ack) begin
              pc <= redir_target;
            end else begin
              drop_target <= redir_target;
              state       <= ST_DROP;
            end
          end else
`endif
          if (imem_ack) begin
            if (!stall) begin
              pc <= next_seq_pc;
            end else begin
              hold_ir <= imem_rdata;
              hold_pc <= pc;
              state   <= ST_HOLD;
              req     <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
`ifndef IF_DELAY_SLOT_EN
          if (redir_ok) begin
            pc    <= redir_target;
            state <= ST_REQ;
            req   <= 1'b1;
          end else
`endif
          if (!stall) begin
            pc    <= next_seq_pc;
            state <= ST_REQ;
            req   <= 1'b1;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            pc    <= redir_ok ? redir_target : drop_target;
            state <= ST_REQ;
          end else if (redir_ok) begin
            drop_target <= redir_target;
          end
        end
        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_DELAY_SLOT_EN
  // Delay-slot bookkeeping: remember a taken branch until the slot is delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= 1'b0;
      pending_target <= '0;
    end else if (deliver) begin
      pending <= 1'b0;
    end else if (redir_take) begin
      pending        <= 1'b1;
      pending_target <= redir_target;
    end
  end
`endif

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (~stall),
    .flush       (ifid_flush),
    .load        (ifid_load),
    .ir_in       (ifid_ir),
    .pc_in       (ifid_pc),
    .IR          (IR),
    .pc_ID       (pc_ID),
    .pc_plus4_ID (pc_plus4_ID),
    .valid_ID    (valid_ID)
  );

endmodule
